// File: rtl/axis_pkg.sv
// Shared types for the Axis burst-reader slice: FSM state encoding, counter
// width and the tagged word carried through the output stage.
package axis_pkg;

  localparam int CNT_W     = 16;
  localparam int AXIS_WORD = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } burst_rd_state_e;

  typedef struct packed {
    logic [AXIS_WORD-1:0] data;
    logic                 last;
  } word_tag_t;

endpackage

// File: rtl/axis_if.sv
// Axis stream bundle: data with a valid/ready handshake; ok marks a transfer.
interface axis_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             ok;

  assign ok = valid & ready;

  modport master (output data, valid, input ready, ok);
  modport slave  (input data, valid, ok, output ready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer: output register plus one overflow slot,
// so upstream ready is a plain flop and throughput is full with ready=1.
module axis_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_data_q;

  assign in_ready = !skid_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid_q) begin
        out_valid    <= 1'b1;
        out_data     <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid_q) begin
      // output stalled: park the incoming word in the overflow slot
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data;
    end
  end

endmodule

// File: rtl/axis_burst_reader.sv
// Drains the async fifo read side into framed bursts of BURST_LEN words,
// flushing a partial burst once the fifo has sat non-empty for TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | waiting for prog_empty to fall or the idle timeout to expire
// BURST | passing BURST_LEN words straight through, last on the final one
// FLUSH | draining a partial burst through a one-word lookahead register
module axis_burst_reader import axis_pkg::*; #(
  parameter int BUFF_WORD      = 32,
  parameter int BURST_LEN      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  axis_if.slave            in_stream,
  input  logic             in_prog_empty,
  input  logic             in_empty,
  axis_if.master           out_stream,
  output logic             out_last,
  output logic [CNT_W-1:0] burst_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  burst_rd_state_e   state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  word_tag_t         held_q, held_d;
  logic              held_valid_q, held_valid_d;
  logic [CNT_W-1:0]  burst_count_d, flush_count_d;

  logic                 in_ready_c;
  logic                 in_ok;
  logic                 skid_in_ready;
  logic                 push_valid;
  logic                 push_last;
  logic [BUFF_WORD-1:0] push_data;
  logic                 skid_out_valid;
  logic [BUFF_WORD:0]   skid_out_data;

  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      BURST:   in_ready_c = skid_in_ready;
      // stop accepting once the held word is known to close the burst
      FLUSH:   in_ready_c = skid_in_ready && !in_empty && !(held_valid_q && held_q.last);
      default: in_ready_c = 1'b0;
    endcase
  end

  assign in_stream.ready = in_ready_c;
  assign in_ok           = in_stream.ok;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    held_d        = held_q;
    held_valid_d  = held_valid_q;
    burst_count_d = burst_count;
    flush_count_d = flush_count;
    push_valid    = 1'b0;
    push_last     = 1'b0;
    push_data     = in_stream.data;

    case (state_q)
      IDLE: begin
        if (in_empty) begin
          idle_cnt_d = '0;
        end else if (in_prog_empty && idle_cnt_q != IDLE_W'(TIMEOUT_CYCLES)) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        if (!in_prog_empty) begin
          state_d    = BURST;
          idle_cnt_d = '0;
          beat_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES) && !in_empty) begin
          state_d      = FLUSH;
          idle_cnt_d   = '0;
          beat_cnt_d   = '0;
          held_valid_d = 1'b0;
        end
      end

      BURST: begin
        if (in_ok) begin
          push_valid = 1'b1;
          push_last  = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
          if (push_last) begin
            state_d       = IDLE;
            beat_cnt_d    = '0;
            burst_count_d = burst_count + CNT_W'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end

      FLUSH: begin
        if (held_valid_q && skid_in_ready) begin
          push_valid = 1'b1;
          push_data  = held_q.data[BUFF_WORD-1:0];
          push_last  = !in_ok;
          if (!in_ok) begin
            state_d       = IDLE;
            beat_cnt_d    = '0;
            held_valid_d  = 1'b0;
            burst_count_d = burst_count + CNT_W'(1);
            flush_count_d = flush_count + CNT_W'(1);
          end
        end
        if (in_ok) begin
          held_d.data  = AXIS_WORD'(in_stream.data);
          held_d.last  = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
          held_valid_d = 1'b1;
          beat_cnt_d   = beat_cnt_q + BEAT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      held_q       <= '0;
      held_valid_q <= 1'b0;
      burst_count  <= '0;
      flush_count  <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      burst_count  <= burst_count_d;
      flush_count  <= flush_count_d;
    end
  end

  axis_skid_buf #(
    .WIDTH(BUFF_WORD + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (push_valid),
    .in_data  ({push_last, push_data}),
    .in_ready (skid_in_ready),
    .out_valid(skid_out_valid),
    .out_data (skid_out_data),
    .out_ready(out_stream.ready)
  );

  assign out_stream.valid = skid_out_valid;
  assign out_stream.data  = skid_out_data[BUFF_WORD-1:0];
  assign out_last         = skid_out_valid & skid_out_data[BUFF_WORD];

endmodule

// File: tb/tb_axis_burst_reader.sv
// Scoreboard bench for axis_burst_reader with BURST_LEN=4, TIMEOUT_CYCLES=8:
// a fifo model feeds the input, a monitor pops expected words as they emerge.
module tb_axis_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_prog_empty;
  logic        in_empty;
  logic        out_last;
  logic [15:0] burst_count;
  logic [15:0] flush_count;

  axis_if #(.WIDTH(32)) in_if ();
  axis_if #(.WIDTH(32)) out_if ();

  axis_burst_reader #(
    .BUFF_WORD     (32),
    .BURST_LEN     (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_stream    (in_if),
    .in_prog_empty(in_prog_empty),
    .in_empty     (in_empty),
    .out_stream   (out_if),
    .out_last     (out_last),
    .burst_count  (burst_count),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic [32:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int pops = 0;
  int gap_at = 0;
  int gap_cnt = 0;
  int out_seen = 0;
  int last_seen = 0;
  int exp_bursts = 0;
  int exp_flushes = 0;
  bit ready_toggle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic preload(input logic [31:0] d);
    fifo_q.push_back(d);
  endtask

  task automatic expect_word(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s drain: pending=%0d required=0", tag, exp_q.size());
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    check({tag, " burst_count"}, 32'(burst_count), 32'(exp_bursts));
    check({tag, " flush_count"}, 32'(flush_count), 32'(exp_flushes));
  endtask

  // fifo read-side model: presents the head word, pops on each transfer
  initial begin : driver
    bit take;
    in_if.valid   = 1'b0;
    in_if.data    = '0;
    in_empty      = 1'b1;
    in_prog_empty = 1'b1;
    out_if.ready  = 1'b1;
    forever begin
      @(negedge clk);
      take = in_if.valid && in_if.ready;
      @(posedge clk);
      #1;
      if (take && !rst && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pops++;
        if (gap_at != 0 && pops == gap_at) gap_cnt = 5;
      end
      if (gap_cnt > 0) begin
        in_if.valid = 1'b0;
        gap_cnt--;
      end else begin
        in_if.valid = (fifo_q.size() > 0);
      end
      in_if.data    = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
      in_empty      = (fifo_q.size() == 0);
      in_prog_empty = (fifo_q.size() < 4);
      out_if.ready  = ready_toggle ? !out_if.ready : 1'b1;
    end
  end

  initial begin : monitor
    logic [32:0] e;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        continue;
      end
      if (!out_if.valid) check("last while idle", 32'(out_last), 32'h0);
      if (prev_stall) begin
        check("stall valid", 32'(out_if.valid), 32'h1);
        check("stall data", out_if.data, prev_data);
        check("stall last", 32'(out_last), 32'(prev_last));
      end
      if (out_if.valid && out_if.ready) begin
        out_seen++;
        if (out_last) last_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected word", out_if.data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out data", out_if.data, e[31:0]);
          check("out last", 32'(out_last), 32'(e[32]));
        end
      end
      prev_stall = out_if.valid && !out_if.ready;
      prev_data  = out_if.data;
      prev_last  = out_last;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base_seen;
    int base_last;
    int n;
    #1 rst = 1'b1;
    #2;
    check("reset out valid", 32'(out_if.valid), 32'h0);
    check("reset out last", 32'(out_last), 32'h0);
    check("reset in ready", 32'(in_if.ready), 32'h0);
    check("reset burst_count", 32'(burst_count), 32'h0);
    check("reset flush_count", 32'(flush_count), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // two back-to-back full bursts
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      preload(32'(i));
      expect_word(32'(i), (i == 3) || (i == 7));
    end
    exp_bursts += 2;
    wait_drain("two bursts");
    check_counts("two bursts");

    // trickle of two words flushed by the timeout
    @(posedge clk);
    base_seen = out_seen;
    preload(32'hA);
    preload(32'hB);
    expect_word(32'hA, 1'b0);
    expect_word(32'hB, 1'b1);
    exp_bursts++;
    exp_flushes++;
    repeat (8) @(negedge clk);
    check("no output before timeout", 32'(out_seen), 32'(base_seen));
    wait_drain("timeout flush");
    check_counts("timeout flush");

    // full burst with output ready toggling
    base_seen = out_seen;
    base_last = last_seen;
    ready_toggle = 1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      preload(32'h30 + 32'(i));
      expect_word(32'h30 + 32'(i), i == 3);
    end
    exp_bursts++;
    wait_drain("toggle ready");
    ready_toggle = 0;
    check("toggle beats", 32'(out_seen - base_seen), 32'd4);
    check("toggle lasts", 32'(last_seen - base_last), 32'd1);
    check_counts("toggle ready");

    // input valid gap of 5 cycles after word 1
    @(posedge clk);
    pops = 0;
    gap_at = 2;
    for (int i = 0; i < 4; i++) begin
      preload(32'h40 + 32'(i));
      expect_word(32'h40 + 32'(i), i == 3);
    end
    exp_bursts++;
    wait_drain("valid gap");
    gap_at = 0;
    check_counts("valid gap");

    // asynchronous reset after two accepted words
    @(posedge clk);
    pops = 0;
    for (int i = 0; i < 4; i++) preload(32'h60 + 32'(i));
    expect_word(32'h60, 1'b0);
    expect_word(32'h61, 1'b0);
    n = 0;
    while (pops < 2 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("reset trigger reached", 32'(pops >= 2), 32'h1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid reset out valid", 32'(out_if.valid), 32'h0);
    check("mid reset out last", 32'(out_last), 32'h0);
    check("mid reset burst_count", 32'(burst_count), 32'h0);
    check("mid reset flush_count", 32'(flush_count), 32'h0);
    check("words before reset", 32'(exp_q.size()), 32'h0);
    fifo_q.delete();
    exp_q.delete();
    exp_bursts = 0;
    exp_flushes = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      preload(32'h70 + 32'(i));
      expect_word(32'h70 + 32'(i), i == 3);
    end
    exp_bursts++;
    wait_drain("after reset");
    check_counts("after reset");

    // prog_empty falls in the same cycle the timeout expires
    @(posedge clk);
    preload(32'h80);
    repeat (8) @(posedge clk);
    for (int i = 1; i < 4; i++) preload(32'h80 + 32'(i));
    for (int i = 0; i < 4; i++) expect_word(32'h80 + 32'(i), i == 3);
    exp_bursts++;
    wait_drain("timeout tie");
    check_counts("timeout tie");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_burst_reader.md
Name: axis_burst_reader

Overview:
- Consumer attached to the read side of the team's async fifo, in the rd_clk domain.
- Watches the fifo's prog_empty/empty status and pulls words from the fifo's Axis master.
- Re-emits the words as framed bursts of BURST_LEN words on its own Axis master, with an end-of-burst flag.
- A partial burst is flushed after an idle timeout, so a trickle of data never stalls in the fifo.

Parameters:
- BUFF_WORD, 32, data width; must equal the fifo's BUFF_WORD.
- BURST_LEN, 16, words per full burst; range 2..256.
- TIMEOUT_CYCLES, 256, cycles of "not prog_empty never reached but fifo non-empty" before a partial flush; at least 1.

Ports:
- clk  input  1  block clock; the fifo rd_clk.
- rst  input  1  reset, asynchronous, active-high.
- in_stream  Axis.Slave  BUFF_WORD  from the fifo rd_stream; uses data, valid, ready, ok (ok = valid & ready).
- in_prog_empty  input  1  fifo prog_empty.
- in_empty  input  1  fifo empty.
- out_stream  Axis.Master  BUFF_WORD  framed burst output; same fields.
- out_last  output  1  qualifies out_stream.data; high on the final word of each burst.
- burst_count  output  16  number of bursts emitted; wraps modulo 2^16.
- flush_count  output  16  number of timeout-flushed (partial) bursts; wraps modulo 2^16.

Behaviour:
- Reset (async assert; deassert is synchronised by the integrator):
  - state IDLE; in_stream.ready=0; out_stream.valid=0; out_last=0.
  - beat_cnt, idle_cnt, burst_count and flush_count all 0.
- State IDLE:
  - in_stream.ready=0.
  - idle_cnt increments each cycle while in_empty=0 and in_prog_empty=1; it saturates at TIMEOUT_CYCLES.
  - idle_cnt clears when in_empty=1.
  - in_prog_empty=0 -> BURST. This takes priority over the timeout when both hold in the same cycle.
  - idle_cnt==TIMEOUT_CYCLES and in_empty=0 -> FLUSH.
  - Either transition clears idle_cnt and beat_cnt.
- State BURST:
  - in_stream.ready=1 whenever the output stage can accept a word.
  - Each in_stream.ok increments beat_cnt.
  - The word accepted with beat_cnt==BURST_LEN-1 is tagged last; on that ok -> IDLE, and burst_count increments.
  - Input valid gaps are tolerated: the block waits in BURST, with no timeout.
- State FLUSH:
  - Accepts words as in BURST, but one word is held in a lookahead register until the end of the burst is known.
  - When a new word arrives, the held word is released with last=0.
  - The held word is released with last=1, then -> IDLE, when either:
    - the cycle after an accept sees in_stream.valid=0 or in_empty=1, or
    - beat_cnt reaches BURST_LEN-1.
  - On that exit, burst_count and flush_count both increment.
  - A FLUSH always emits at least 1 word and at most BURST_LEN words.
- Output stage:
  - 2-entry skid buffer; out_stream.valid and data are registered.
  - Latency is 1 cycle from in ok to out valid in BURST, and 2 cycles in FLUSH.
  - No bubbles while out_stream.ready=1.
  - out_stream.valid/data/out_last are held stable while valid=1 and ready=0.
- Backpressure: when the skid buffer is full, in_stream.ready=0 in every state. No word is dropped or duplicated.
- out_last is 0 whenever out_stream.valid=0.
- Boundaries:
  - If the fifo goes empty mid-BURST, the block stalls; the frame is not truncated.
  - If rst asserts mid-burst, the frame in flight is discarded and outputs return to reset values immediately.
  - Counter wrap from 0xFFFF to 0 is silent.

Decomposition:
- Shared package axis_pkg holds:
  - state enum burst_rd_state_e {IDLE, BURST, FLUSH};
  - constant CNT_W=16;
  - typedef word_tag_t, a struct of data and last.
- One sub-module, axis_skid_buf (parameter WIDTH), is the 2-entry registered skid buffer. It is instantiated here with width BUFF_WORD+1 and is reusable elsewhere.

Test Plan:
All cases use BURST_LEN=4 and TIMEOUT_CYCLES=8.
- Preload 8 words 0..7, prog_empty=0, out ready=1 -> 2 bursts 0-3 and 4-7; out_last on words 3 and 7; burst_count=2; flush_count=0.
- Preload 2 words 0xA, 0xB with prog_empty=1 held -> no output for 8 cycles, then 0xA (last=0) and 0xB (last=1); flush_count=1.
- Full burst with out ready toggling 1/0 every cycle -> order 0..3 preserved, data stable while stalled, exactly 4 beats, 1 last.
- Input valid drops for 5 cycles after word 1 of a BURST -> stays in BURST; frame completes at word 3 with no early last.
- Assert rst asynchronously after 2 accepted words -> out valid=0 and counters=0 within the same cycle; the next burst starts clean at beat 0.
- Timeout and prog_empty falling in the same cycle -> BURST is taken; 4-word frame; flush_count unchanged.
